// File: rtl/accumulator4_sequencer.sv
// Instruction sequencer for the accumulator4 block. It fetches 16-bit words from
// program memory, issues ALU ops as one-cycle enable pulses, and resolves branches on acc flags.
module accumulator4_sequencer #(
  parameter int PC_W       = 8,
  parameter int START_ADDR = 0
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  input  logic [7:0]      acc_value,
  input  logic            acc_carry,
  output logic            alu_enable,
  output logic [4:0]      alu_opcode,
  output logic [3:0]      alu_operand_hi,
  output logic [3:0]      alu_operand_lo,
  output logic            alu_carry,
  output logic            busy,
  output logic            halted,
  output logic            fault,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      dbg_state
);

  // Handshakes: imem_req is held with a stable imem_addr for every FETCH cycle and the
  // word is taken in the cycle imem_ack is high; alu_enable is a single-cycle pulse
  // with no back-pressure, and operands are zero whenever it is low.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_ISSUE   = 3'd3,
    S_SETTLE  = 3'd4,
    S_HALTED  = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            rst_done_q;

  logic            flag_z, flag_s, flag_c;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;

  function automatic logic alu_legal(input logic [4:0] op);
    case (op)
      5'h01, 5'h02, 5'h03, 5'h05, 5'h06, 5'h07, 5'h09, 5'h0A, 5'h0B,
      5'h0D, 5'h0E, 5'h0F, 5'h11, 5'h12, 5'h14, 5'h15, 5'h16, 5'h17: alu_legal = 1'b1;
      default: alu_legal = 1'b0;
    endcase
  endfunction

  assign flag_z = (acc_value == 8'h00);
  assign flag_s = acc_value[7];
  assign flag_c = acc_carry;
  assign pc_inc = pc_q + PC_ONE;
  assign target = ir_q[PC_W-1:0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      rst_done_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      // rst_done_q masks a start that coincides with the first edge after reset
      S_IDLE: begin
        if (start && rst_done_q) begin
          pc_d    = START_PC;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        case (ir_q[15:13])
          3'b000: begin
            if (alu_legal(ir_q[12:8])) begin
              pc_d    = pc_inc;
              state_d = S_ISSUE;
            end else begin
              state_d = S_FAULT;
            end
          end
          3'b001:  pc_d = target;
          3'b010:  pc_d = flag_z  ? target : pc_inc;
          3'b011:  pc_d = !flag_z ? target : pc_inc;
          3'b100:  pc_d = flag_c  ? target : pc_inc;
          3'b101:  pc_d = flag_s  ? target : pc_inc;
          3'b110:  pc_d = pc_inc;
          default: state_d = S_HALTED;
        endcase
      end
      S_ISSUE:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_FETCH;
      S_HALTED, S_FAULT: begin
        if (start) begin
          pc_d    = START_PC;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req       = (state_q == S_FETCH);
    imem_addr      = pc_q;
    alu_enable     = (state_q == S_ISSUE);
    alu_opcode     = '0;
    alu_operand_hi = '0;
    alu_operand_lo = '0;
    if (state_q == S_ISSUE) begin
      alu_opcode     = ir_q[12:8];
      alu_operand_hi = ir_q[7:4];
      alu_operand_lo = ir_q[3:0];
    end
    alu_carry = acc_carry;
    busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                (state_q == S_ISSUE) || (state_q == S_SETTLE);
    halted    = (state_q == S_HALTED);
    fault     = (state_q == S_FAULT);
    pc        = pc_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_accumulator4_sequencer.sv
// Directed bench for accumulator4_sequencer: a program-memory responder with optional
// wait states, plus fetch-address and ALU-issue scoreboards fed from each test step.
module tb_accumulator4_sequencer;

  localparam int PC_W = 8;

  logic            aclk;
  logic            aresetn;
  logic            start;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_data;
  logic [7:0]      acc_value;
  logic            acc_carry;
  logic            alu_enable;
  logic [4:0]      alu_opcode;
  logic [3:0]      alu_operand_hi;
  logic [3:0]      alu_operand_lo;
  logic            alu_carry;
  logic            busy;
  logic            halted;
  logic            fault;
  logic [PC_W-1:0] pc;
  logic [2:0]      dbg_state;

  accumulator4_sequencer #(.PC_W(PC_W), .START_ADDR(8'hFF)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .acc_value(acc_value), .acc_carry(acc_carry),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode),
    .alu_operand_hi(alu_operand_hi), .alu_operand_lo(alu_operand_lo), .alu_carry(alu_carry),
    .busy(busy), .halted(halted), .fault(fault), .pc(pc), .dbg_state(dbg_state)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] imem [256];
  logic [7:0]  exp_fetch_q[$];
  logic [12:0] exp_q[$];
  int          ack_delay = 0;
  int          wait_left = 0;
  int          cyc = 0;
  int          last_ack = 0;
  int          fetch_gap = 0;
  int          prev_gap = 0;
  int          alu_cnt = 0;
  logic        en_prev = 1'b0;

  // branch table: class, acc_value, acc_carry, taken
  logic [2:0] br_cls   [8] = '{3'b010, 3'b010, 3'b011, 3'b011, 3'b100, 3'b100, 3'b101, 3'b101};
  logic [7:0] br_acc   [8] = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h7F};
  logic       br_cy    [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       br_taken [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {29'd0, imem_req, imem_addr, alu_enable, alu_opcode, alu_operand_hi,
            alu_operand_lo, alu_carry, busy, halted, fault, pc};
  endfunction

  // memory responder and scoreboards
  always @(negedge aclk) begin
    cyc++;
    if (!imem_req) begin
      imem_ack  = 1'b0;
      wait_left = ack_delay;
    end else if (wait_left == 0) begin
      imem_ack  = 1'b1;
      imem_data = imem[imem_addr];
      check("fetch_expected", 64'(exp_fetch_q.size() != 0), 64'd1);
      if (exp_fetch_q.size() != 0) check("fetch_addr", 64'(imem_addr), 64'(exp_fetch_q.pop_front()));
      prev_gap  = fetch_gap;
      fetch_gap = cyc - last_ack;
      last_ack  = cyc;
    end else begin
      imem_ack  = 1'b0;
      wait_left = wait_left - 1;
    end
    if (alu_enable) begin
      alu_cnt++;
      check("alu_pulse_single", 64'(en_prev), 64'd0);
      check("alu_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0)
        check("alu_word", 64'({alu_opcode, alu_operand_hi, alu_operand_lo}), 64'(exp_q.pop_front()));
    end
    en_prev = alu_enable;
  end

  // driver tasks
  task automatic pulse_start();
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic wait_stop(input string tag);
    for (int i = 0; i < 60 && !(halted || fault); i++) @(negedge aclk);
    check(tag, 64'(halted | fault), 64'd1);
  endtask

  task automatic wait_enable();
    for (int i = 0; i < 30 && !alu_enable; i++) @(negedge aclk);
    check("enable_seen", 64'(alu_enable), 64'd1);
  endtask

  initial begin
    int cnt0;
    logic [7:0] tgt;
    aresetn   = 1'b0;
    start     = 1'b0;
    acc_value = 8'h01;
    acc_carry = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
    for (int i = 0; i < 256; i++) imem[i] = 16'hE000;

    // reset state, then start coinciding with reset release is ignored
    repeat (3) @(negedge aclk);
    check("reset_outputs", all_outs(), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    aresetn = 1'b1;
    start   = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    repeat (3) @(negedge aclk);
    check("start_at_release_busy", 64'(busy), 64'd0);
    check("start_at_release_req", 64'(imem_req), 64'd0);

    // wrap: NOP at 0xFF, HALT at 0x00
    imem[8'hFF] = 16'hC000;
    imem[8'h00] = 16'hE000;
    exp_fetch_q.push_back(8'hFF);
    exp_fetch_q.push_back(8'h00);
    pulse_start();
    check("wrap_first_addr", 64'(imem_addr), 64'hFF);
    check("wrap_busy", 64'(busy), 64'd1);
    wait_stop("wrap_stop");
    check("wrap_halted", 64'({halted, fault, busy}), 64'b100);
    check("wrap_pc", 64'(pc), 64'h00);
    check("nop_latency", 64'(fetch_gap), 64'd2);
    exp_fetch_q.push_back(8'hFF);
    exp_fetch_q.push_back(8'h00);
    pulse_start();
    check("restart_halted_clear", 64'(halted), 64'd0);
    check("restart_addr", 64'(imem_addr), 64'hFF);
    wait_stop("restart_stop");
    check("restart_pc", 64'(pc), 64'h00);

    // illegal opcode 00 faults without an enable pulse
    imem[8'hFF] = 16'h2010;
    imem[8'h10] = 16'h0012;
    imem[8'h11] = 16'h0131;
    imem[8'h12] = 16'hE000;
    exp_fetch_q.push_back(8'hFF);
    exp_fetch_q.push_back(8'h10);
    cnt0 = alu_cnt;
    pulse_start();
    wait_stop("illegal_stop");
    check("illegal_flags", 64'({halted, fault, busy}), 64'b010);
    check("illegal_pc", 64'(pc), 64'h10);
    check("illegal_no_enable", 64'(alu_cnt - cnt0), 64'd0);

    // issue timing, then BZ sees the value updated after the op
    imem[8'hFF] = 16'h2020;
    imem[8'h20] = 16'h0335;
    imem[8'h21] = 16'h4030;
    imem[8'h30] = 16'hE000;
    exp_fetch_q.push_back(8'hFF);
    exp_fetch_q.push_back(8'h20);
    exp_fetch_q.push_back(8'h21);
    exp_fetch_q.push_back(8'h30);
    exp_q.push_back(13'h0335);
    acc_value = 8'h01;
    acc_carry = 1'b1;
    pulse_start();
    wait_enable();
    check("issue_opcode", 64'(alu_opcode), 64'h03);
    check("issue_hi_lo", 64'({alu_operand_hi, alu_operand_lo}), 64'h35);
    check("issue_carry", 64'(alu_carry), 64'd1);
    acc_value = 8'h00;
    @(negedge aclk);
    check("settle_outputs", 64'({alu_enable, alu_opcode, alu_operand_hi, alu_operand_lo}), 64'd0);
    check("settle_state", 64'(dbg_state), 64'd4);
    wait_stop("issue_stop");
    check("issue_pc", 64'(pc), 64'h30);
    check("alu_latency", 64'(prev_gap), 64'd4);
    check("branch_latency", 64'(fetch_gap), 64'd2);
    acc_carry = 1'b0;

    // branches, taken and not taken
    for (int i = 0; i < 8; i++) begin
      imem[8'hFF] = 16'h2040;
      imem[8'h40] = {br_cls[i], 5'd0, 8'h50};
      imem[8'h41] = 16'hE000;
      imem[8'h50] = 16'hE000;
      acc_value = br_acc[i];
      acc_carry = br_cy[i];
      tgt = br_taken[i] ? 8'h50 : 8'h41;
      exp_fetch_q.push_back(8'hFF);
      exp_fetch_q.push_back(8'h40);
      exp_fetch_q.push_back(tgt);
      pulse_start();
      wait_stop("branch_stop");
      check($sformatf("branch_pc_%0d", i), 64'(pc), 64'(tgt));
    end
    acc_carry = 1'b0;
    acc_value = 8'h01;

    // wait states on every fetch
    ack_delay = 3;
    imem[8'hFF] = 16'h2060;
    imem[8'h60] = 16'h0101;
    imem[8'h61] = 16'hE000;
    exp_fetch_q.push_back(8'hFF);
    exp_fetch_q.push_back(8'h60);
    exp_fetch_q.push_back(8'h61);
    exp_q.push_back(13'h0101);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      check("wait_req_addr", 64'({imem_req, imem_addr, alu_enable}), 64'({1'b1, 8'hFF, 1'b0}));
      @(negedge aclk);
    end
    wait_stop("wait_stop");
    check("wait_pc", 64'(pc), 64'h61);
    check("wait_jmp_gap", 64'(prev_gap), 64'd5);
    check("wait_alu_gap", 64'(fetch_gap), 64'd7);
    ack_delay = 0;

    // reset asserted during ISSUE
    imem[8'hFF] = 16'h2070;
    imem[8'h70] = 16'h0F12;
    exp_fetch_q.push_back(8'hFF);
    exp_fetch_q.push_back(8'h70);
    exp_q.push_back(13'h0F12);
    pulse_start();
    wait_enable();
    #2 aresetn = 1'b0;
    #1;
    check("reset_mid_issue_outputs", all_outs(), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (5) @(negedge aclk);
    check("post_reset_idle", 64'({imem_req, busy, dbg_state}), 64'd0);

    check("fetch_queue_drained", 64'(exp_fetch_q.size()), 64'd0);
    check("alu_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
